// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits between the EX/MEM stage and data_memory. It turns byte-addressed
//   lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-indexed memory accesses.
//   Loads select the addressed lane and then sign- or zero-extend it.
//   Sub-word stores use a read-modify-write sequence (RMW_RD then RMW_WR).
//   The unit accepts one request at a time, and only while in IDLE.
//
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned half/word
//   accesses. Such a request completes in one cycle with o_resp_err=1 and
//   makes no memory access. When the macro is undefined, o_resp_err is tied 0
//   and the low address bits below the access size are ignored.
//
// Ports
//   i_clock, i_reset       clock; synchronous active-high reset
//   i_req_*, o_req_ready   request handshake (write, size, unsigned, addr, wdata)
//   o_resp_valid/_rdata/_err  one-cycle completion pulse, extended load data, misalign flag
//   o_mem_*, i_mem_rdata   data_memory port (word index; registered read data)
module load_store_unit #(
    parameter int ADDR_W = 6
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_LD_RD, S_LD_EXT, S_ST_WR, S_RMW_RD, S_RMW_WR
    } state_t;

    state_t              r_state;
    logic                r_write;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic                w_misalign;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merged;
    logic                w_unused;

    // Address bits above the word index are ignored: accesses wrap modulo memory size.
    assign w_unused = ^{i_req_addr[31:ADDR_W+2], r_write};

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                        (i_req_size[1] && (i_req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane extraction for loads. Lanes are little-endian.
    assign w_byte = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        w_load_data = i_mem_rdata;
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    // Replace the addressed lane(s) of the old word with the store data.
    // For a half store, byte i takes wdata byte (i%2) when addr[1] selects it.
    always_comb begin
        w_merged = i_mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_size == 2'b00 && r_addr[1:0] == i[1:0])
                w_merged[8*i +: 8] = r_wdata[7:0];
            else if (r_size == 2'b01 && r_addr[1] == i[1])
                w_merged[8*i +: 8] = r_wdata[8*(i%2) +: 8];
        end
    end

    // Memory controls decode from state, so read and write are mutually exclusive.
    assign o_req_ready   = (r_state == S_IDLE);
    assign o_mem_read    = (r_state == S_LD_RD) || (r_state == S_RMW_RD);
    assign o_mem_write   = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
    assign o_mem_address = {{(32-ADDR_W){1'b0}}, r_addr[ADDR_W+1:2]};
    assign o_mem_wdata   = (r_state == S_RMW_WR) ? w_merged : r_wdata;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_rdata  = r_resp_rdata;
`ifdef MISALIGN_TRAP_EN
    assign o_resp_err    = r_resp_err;
`else
    assign o_resp_err    = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write    <= i_req_write;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_addr     <= i_req_addr[ADDR_W+1:0];
                        r_wdata    <= i_req_wdata;
                        if (w_misalign) begin
                            // Trap: complete at once and touch no memory.
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!i_req_write)
                            r_state <= S_LD_RD;
                        else if (i_req_size[1])
                            r_state <= S_ST_WR;
                        else
                            r_state <= S_RMW_RD;
                    end
                end
                S_LD_RD:  r_state <= S_LD_EXT;
                S_LD_EXT: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                    r_state      <= S_IDLE;
                end
                S_ST_WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_RMW_RD: r_state <= S_RMW_WR;
                S_RMW_WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default:  r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a registered-read data_memory model,
// directed cases, and a randomized stream checked against a reference word array.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(6)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_mem_address(mem_address), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // data_memory: registered read, write not gated by reset
    logic [31:0] mem      [64];
    logic [31:0] init_val [64];
    logic [31:0] ref_mem  [64];
    logic        init_mem = 1'b0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
        end else if (mem_write) mem[mem_address[5:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_address[5:0]];
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic u, input logic [31:0] a);
        logic [31:0] w, v;
        w = ref_mem[a[7:2]];
        if (sz == 2'd0) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else v = w;
        return v;
    endfunction

    function automatic logic [31:0] st_model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w, m;
        w = ref_mem[a[7:2]];
        if (sz == 2'd0) begin
            m = 32'hFF << (8 * a[1:0]);
            w = (w & ~m) | ((d & 32'hFF) << (8 * a[1:0]));
        end else if (sz == 2'd1) begin
            m = 32'hFFFF << (16 * a[1]);
            w = (w & ~m) | ((d & 32'hFFFF) << (16 * a[1]));
        end else w = d;
        return w;
    endfunction

    // ---------------- driver / monitor ----------------
    int          lat, nrd, nwr, nbusy, both;
    logic [31:0] got_rdata, last_wdata;
    logic        got_err;

    // Called between a negedge and the next posedge; returns in the resp cycle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        int g;
        logic done;
        g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        chk("ready_at_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; nbusy = 0; both = 0; done = 1'b0;
        got_rdata = '0; got_err = 1'b0; last_wdata = '0;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge clk);
            if (mem_read) begin
                nrd++;
                chk("rd_addr", mem_address, {26'b0, a[7:2]});
            end
            if (mem_write) begin
                nwr++;
                last_wdata = mem_wdata;
                chk("wr_addr", mem_address, {26'b0, a[7:2]});
            end
            if (mem_read && mem_write) both++;
            if (!req_ready) nbusy++;
            if (resp_valid) begin
                done = 1'b1; lat = c; got_rdata = resp_rdata; got_err = resp_err;
            end
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
        logic        mis;
        logic [31:0] exp_rd, nw;
        int          exp_lat, exp_nrd, exp_nwr;
        mis     = is_mis(sz, a);
        exp_rd  = (w || mis) ? 32'd0 : ld_model(sz, u, a);
        nw      = st_model(sz, a, d);
        exp_lat = mis ? 1 : (!w ? 3 : (sz < 2'd2 ? 3 : 2));
        exp_nrd = mis ? 0 : ((!w || sz < 2'd2) ? 1 : 0);
        exp_nwr = (mis || !w) ? 0 : 1;
        do_req(w, sz, u, a, d);
        chk({tag, "_lat"},   32'(lat),     32'(exp_lat));
        chk({tag, "_busy"},  32'(nbusy),   32'(exp_lat - 1));
        chk({tag, "_nrd"},   32'(nrd),     32'(exp_nrd));
        chk({tag, "_nwr"},   32'(nwr),     32'(exp_nwr));
        chk({tag, "_both"},  32'(both),    32'd0);
        chk({tag, "_rdata"}, got_rdata,    exp_rd);
        chk({tag, "_err"},   32'(got_err), 32'(mis));
        if (w && !mis) begin
            chk({tag, "_wdata"}, last_wdata, nw);
            ref_mem[a[7:2]] = nw;
        end
    endtask

    initial begin
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 64; i++) init_val[i] = $urandom;
        init_val[3] = 32'h8899_AABB;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val[i];

        rst = 1'b1; init_mem = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(req_ready),  32'd1);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_rdata",  resp_rdata,      32'd0);
        chk("rst_err",    32'(resp_err),   32'd0);
        chk("rst_mrd",    32'(mem_read),   32'd0);
        chk("rst_mwr",    32'(mem_write),  32'd0);
        rst = 1'b0; init_mem = 1'b0;
        @(negedge clk);

        // 1: lw 0x0C
        run("lw0C", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        chk("t1_data", got_rdata, 32'h8899_AABB);
        // 2: sub-word loads with extension
        run("lb0D",  1'b0, 2'd0, 1'b0, 32'h0D, 32'h0);
        chk("t2_lb", got_rdata, 32'hFFFF_FFAA);
        run("lbu0D", 1'b0, 2'd0, 1'b1, 32'h0D, 32'h0);
        chk("t2_lbu", got_rdata, 32'h0000_00AA);
        run("lh0E",  1'b0, 2'd1, 1'b0, 32'h0E, 32'h0);
        chk("t2_lh", got_rdata, 32'hFFFF_8899);
        run("lhu0E", 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
        chk("t2_lhu", got_rdata, 32'h0000_8899);
        // 4: sh then back-to-back lhu (issued in the resp cycle)
        run("sh0C", 1'b1, 2'd1, 1'b0, 32'h0C, 32'hDEAD_1234);
        chk("t4_merge", last_wdata, 32'h8899_1234);
        chk("t4_b2b_ready", 32'(req_ready), 32'd1);
        run("lhu0C", 1'b0, 2'd1, 1'b1, 32'h0C, 32'h0);
        chk("t4_data", got_rdata, 32'h0000_1234);
        // restore word 3, then 3: sb 0x0E
        run("sw0C", 1'b1, 2'd2, 1'b0, 32'h0C, 32'h8899_AABB);
        run("sb0E", 1'b1, 2'd0, 1'b0, 32'h0E, 32'h0000_0011);
        chk("t3_merge", last_wdata, 32'h8811_AABB);
        run("lw0C_b", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        chk("t3_data", got_rdata, 32'h8811_AABB);
        run("sw0C_b", 1'b1, 2'd2, 1'b0, 32'h0C, 32'h8899_AABB);

        // 5: reset during RMW_RD of sb 0x0C
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0C; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t5_in_rmwrd", 32'(mem_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_ready", 32'(req_ready),  32'd1);
        chk("t5_rvalid", 32'(resp_valid), 32'd0);
        chk("t5_mrd",   32'(mem_read),   32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_no_wr",   32'(mem_write),  32'd0);
            chk("t5_no_resp", 32'(resp_valid), 32'd0);
        end
        run("lw0C_c", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        chk("t5_word3", got_rdata, 32'h8899_AABB);

        // 6: misaligned lw 0x0D
        run("lw0D", 1'b0, 2'd2, 1'b0, 32'h0D, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("t6_err", 32'(got_err), 32'd1);
`else
        chk("t6_data", got_rdata, 32'h8899_AABB);
`endif

        // randomized stream, full 32-bit addresses to exercise wrap
        for (int k = 0; k < 250; k++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [31:0] a, d;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = (k % 3 == 0) ? $urandom : 32'($urandom_range(0, 31));
            d  = $urandom;
            run("rnd", w, sz, u, a, d);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
